// File: rtl/i2c_glitch_trigger_pkg.sv
// Shared definitions for the I2C glitch trigger: state encodings, byte layout
// and small helpers used by the controller.
package i2c_glitch_trigger_pkg;

  localparam int I2C_WIDTH_DEF = 9;
  localparam int ACK_BIT       = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_DELAY = 3'd4;
  localparam logic [2:0] ST_PULSE = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  function automatic logic state_busy(input logic [2:0] state);
    return !((state == ST_IDLE) || (state == ST_DONE));
  endfunction

endpackage

// File: rtl/i2c_glitch_trigger_if.sv
// Decoded I2C byte stream as produced by the passive listener.
interface i2c_glitch_trigger_if #(
  parameter int I2C_WIDTH = i2c_glitch_trigger_pkg::I2C_WIDTH_DEF
);
  logic [I2C_WIDTH-1:0] byte_in;
  logic                 byte_ready;
  logic                 sop;
  logic                 eot;

  modport master (output byte_in, output byte_ready, output sop, output eot);
  modport slave  (input  byte_in, input  byte_ready, input  sop, input  eot);
endinterface

// File: rtl/i2c_glitch_trigger_down_counter.sv
// Loadable down counter that stops at zero; used for the delay and pulse phases.
module i2c_glitch_trigger_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/i2c_glitch_trigger.sv
// Glitch trigger controller: matches an address/data byte in the I2C stream,
// waits a programmed delay, then emits a single glitch pulse (one-shot per arm).
module i2c_glitch_trigger
  import i2c_glitch_trigger_pkg::*;
#(
  parameter int I2C_WIDTH = I2C_WIDTH_DEF,
  parameter int DELAY_W   = 16,
  parameter int PULSE_W   = 8,
  parameter int IDX_W     = 4
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  i2c_glitch_trigger_if.slave  stream,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [7:0]           match_addr,
  input  logic [7:0]           match_data,
  input  logic [7:0]           match_mask,
  input  logic [IDX_W-1:0]     match_index,
  input  logic                 ack_req,
  input  logic [DELAY_W-1:0]   delay_cycles,
  input  logic [PULSE_W-1:0]   pulse_len,
  output logic                 glitch_out,
  output logic                 busy,
  output logic                 fired,
  output logic [2:0]           state_dbg
);

  logic [2:0]         r_state;
  logic               r_glitch;
  logic [IDX_W-1:0]   r_byte_cnt;
  logic [7:0]         r_cfg_addr;
  logic [7:0]         r_cfg_data;
  logic [7:0]         r_cfg_mask;
  logic [IDX_W-1:0]   r_cfg_index;
  logic               r_cfg_ack_req;
  logic [DELAY_W-1:0] r_cfg_delay;
  logic [PULSE_W-1:0] r_cfg_pulse_m1;

  logic [2:0]         w_state_nxt;
  logic               w_enter_delay;
  logic               w_enter_pulse;
  logic               w_clr_cnt;
  logic               w_inc_cnt;
  logic               w_latch_cfg;
  logic               w_dly_zero;
  logic               w_pls_zero;
  logic [I2C_WIDTH-1:0] w_byte;
  logic [7:0]         w_data;
  logic               w_ack_ok;
  logic               w_addr_hit;
  logic               w_data_hit;
  logic [IDX_W-1:0]   w_cnt_inc;

  assign w_byte     = stream.byte_in;
  assign w_data     = w_byte[ACK_BIT+8:ACK_BIT+1];
  assign w_ack_ok   = !r_cfg_ack_req || !w_byte[ACK_BIT];
  assign w_addr_hit = (w_data == r_cfg_addr) && w_ack_ok;
  assign w_data_hit = (((w_data ^ r_cfg_data) & r_cfg_mask) == 8'h00) && w_ack_ok;
  assign w_cnt_inc  = (r_byte_cnt == '1) ? r_byte_cnt : r_byte_cnt + IDX_W'(1);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_enter_delay = 1'b0;
    w_clr_cnt     = 1'b0;
    w_inc_cnt     = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (arm) w_state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (stream.sop) begin
            w_state_nxt = ST_ADDR;
            w_clr_cnt   = 1'b1;
          end
        end
        ST_ADDR, ST_DATA: begin
          // Repeated start wins over a byte in the same cycle; stop beats a byte.
          if (stream.sop) begin
            w_state_nxt = ST_ADDR;
            w_clr_cnt   = 1'b1;
          end else if (stream.eot) begin
            w_state_nxt = ST_ARMED;
          end else if (stream.byte_ready) begin
            if (r_state == ST_ADDR) begin
              if (!w_addr_hit) begin
                w_state_nxt = ST_ARMED;
              end else if (r_cfg_index == '0) begin
                w_state_nxt   = ST_DELAY;
                w_enter_delay = 1'b1;
              end else begin
                w_state_nxt = ST_DATA;
              end
            end else begin
              w_inc_cnt = 1'b1;
              if (w_cnt_inc == r_cfg_index) begin
                if (w_data_hit) begin
                  w_state_nxt   = ST_DELAY;
                  w_enter_delay = 1'b1;
                end else begin
                  w_state_nxt = ST_ARMED;
                end
              end
            end
          end
        end
        ST_DELAY: if (w_dly_zero) w_state_nxt = ST_PULSE;
        ST_PULSE: if (w_pls_zero) w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_enter_pulse = (r_state == ST_DELAY) && (w_state_nxt == ST_PULSE);
  assign w_latch_cfg   = (w_state_nxt == ST_ARMED) &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_glitch   <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_glitch <= (w_state_nxt == ST_PULSE);
      if (w_clr_cnt) begin
        r_byte_cnt <= '0;
      end else if (w_inc_cnt) begin
        r_byte_cnt <= w_cnt_inc;
      end
    end
  end

  // NOTE: config registers are plain flops, not a memory, so they take the
  // async reset like everything else and never hold stale values after reset.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_addr     <= '0;
      r_cfg_data     <= '0;
      r_cfg_mask     <= '0;
      r_cfg_index    <= '0;
      r_cfg_ack_req  <= 1'b0;
      r_cfg_delay    <= '0;
      r_cfg_pulse_m1 <= '0;
    end else if (w_latch_cfg) begin
      r_cfg_addr     <= match_addr;
      r_cfg_data     <= match_data;
      r_cfg_mask     <= match_mask;
      r_cfg_index    <= match_index;
      r_cfg_ack_req  <= ack_req;
      r_cfg_delay    <= delay_cycles;
      // A zero length still yields a one-cycle pulse.
      r_cfg_pulse_m1 <= (pulse_len == '0) ? '0 : pulse_len - PULSE_W'(1);
    end
  end

  i2c_glitch_trigger_down_counter #(.W(DELAY_W)) u_delay_cnt (
    .clk        (sysclk),
    .rst_n      (rst_n),
    .i_load     (w_enter_delay),
    .i_en       (r_state == ST_DELAY),
    .i_load_val (r_cfg_delay),
    .o_zero     (w_dly_zero)
  );

  i2c_glitch_trigger_down_counter #(.W(PULSE_W)) u_pulse_cnt (
    .clk        (sysclk),
    .rst_n      (rst_n),
    .i_load     (w_enter_pulse),
    .i_en       (r_state == ST_PULSE),
    .i_load_val (r_cfg_pulse_m1),
    .o_zero     (w_pls_zero)
  );

  assign glitch_out = r_glitch;
  assign busy       = state_busy(r_state);
  assign fired      = (r_state == ST_DONE);
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_i2c_glitch_trigger.sv
// Self-checking bench: directed vector table, corner-case sequences and
// randomized byte streams checked against a transaction-level model.
module tb_i2c_glitch_trigger;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  mask;
    logic [3:0]  idx;
    logic        ack_req;
    logic [15:0] dly;
    logic [7:0]  pls;
  } cfg_t;

  typedef struct {
    cfg_t            cfg;
    int              nb;
    logic [2:0][8:0] b;
    bit              exp_fire;
    int              exp_rise;
    int              exp_width;
  } vec_t;

  localparam int EV_IDLE = 0, EV_SOP = 1, EV_EOT = 2, EV_BYTE = 3;
  localparam int NEV = 14, TAIL = 14, NVEC = 10;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        arm = 1'b0, abort = 1'b0, ack_req = 1'b0;
  logic [7:0]  match_addr = '0, match_data = '0, match_mask = '0;
  logic [3:0]  match_index = '0;
  logic [15:0] delay_cycles = '0;
  logic [7:0]  pulse_len = '0;
  logic        glitch_out, busy, fired;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int ev_kind [NEV];
  logic [8:0] ev_byte [NEV];
  vec_t vecs [NVEC];

  i2c_glitch_trigger_if #(.I2C_WIDTH(9)) bus ();

  i2c_glitch_trigger dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .stream       (bus),
    .arm          (arm),
    .abort        (abort),
    .match_addr   (match_addr),
    .match_data   (match_data),
    .match_mask   (match_mask),
    .match_index  (match_index),
    .ack_req      (ack_req),
    .delay_cycles (delay_cycles),
    .pulse_len    (pulse_len),
    .glitch_out   (glitch_out),
    .busy         (busy),
    .fired        (fired),
    .state_dbg    (state_dbg)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] enc(input logic [7:0] d, input logic a);
    return {d, a};
  endfunction

  function automatic cfg_t mk_cfg(input logic [7:0] a, input logic [7:0] d, input logic [7:0] m,
                                  input logic [3:0] i, input logic ar, input logic [15:0] dl,
                                  input logic [7:0] p);
    cfg_t c;
    c.addr = a; c.data = d; c.mask = m; c.idx = i; c.ack_req = ar; c.dly = dl; c.pls = p;
    return c;
  endfunction

  function automatic vec_t mk_vec(input cfg_t c, input int nb, input logic [8:0] b0,
                                  input logic [8:0] b1, input logic [8:0] b2, input bit f,
                                  input int r, input int w);
    vec_t v;
    v.cfg = c; v.nb = nb; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
    v.exp_fire = f; v.exp_rise = r; v.exp_width = w;
    return v;
  endfunction

  // Outputs are sampled 1 time unit after each rising edge; strobes last one cycle.
  task automatic tick();
    @(posedge sysclk);
    #1;
    bus.byte_ready = 1'b0;
    bus.sop        = 1'b0;
    bus.eot        = 1'b0;
    arm            = 1'b0;
    abort          = 1'b0;
  endtask

  task automatic do_arm(input cfg_t c);
    match_addr = c.addr; match_data = c.data; match_mask = c.mask; match_index = c.idx;
    ack_req = c.ack_req; delay_cycles = c.dly; pulse_len = c.pls;
    arm = 1'b1;
    tick();
    // Config is only sampled on arm; scramble inputs afterwards.
    match_addr = 8'($urandom); match_data = 8'($urandom); match_mask = 8'($urandom);
    match_index = 4'($urandom); ack_req = 1'($urandom); delay_cycles = 16'($urandom);
    pulse_len = 8'($urandom);
  endtask

  task automatic do_sop();   bus.sop = 1'b1; tick(); endtask
  task automatic do_eot();   bus.eot = 1'b1; tick(); endtask
  task automatic do_abort(); abort = 1'b1;   tick(); endtask
  task automatic do_byte(input logic [8:0] b);
    bus.byte_in = b; bus.byte_ready = 1'b1; tick();
  endtask

  task automatic measure(input int span, output int rise, output int width);
    rise = 0; width = 0;
    for (int k = 1; k <= span; k++) begin
      tick();
      if (glitch_out) begin
        if (rise == 0) rise = k;
        width++;
      end
    end
  endtask

  // Transaction-level reference: index of the event that triggers, or -1.
  function automatic int model_fire(input cfg_t c);
    bit in_txn;
    int pos;
    bit ok;
    logic [7:0] d;
    in_txn = 0; pos = 0;
    for (int i = 0; i < NEV; i++) begin
      if (ev_kind[i] == EV_SOP) begin
        in_txn = 1; pos = 0;
      end else if (ev_kind[i] == EV_EOT) begin
        in_txn = 0;
      end else if (ev_kind[i] == EV_BYTE && in_txn) begin
        d  = ev_byte[i][8:1];
        ok = !c.ack_req || (ev_byte[i][0] == 1'b0);
        if (pos == 0) begin
          if (d != c.addr) ok = 0;
          if (!ok) in_txn = 0;
          else if (c.idx == 0) return i;
        end else if (pos == int'(c.idx)) begin
          for (int b = 0; b < 8; b++)
            if (c.mask[b] && (d[b] != c.data[b])) ok = 0;
          if (ok) return i;
          in_txn = 0;
        end
        pos++;
      end
    end
    return -1;
  endfunction

  initial begin
    cfg_t c;
    int rise, width, fc, p, d, r;
    bus.byte_in = '0; bus.byte_ready = 1'b0; bus.sop = 1'b0; bus.eot = 1'b0;

    // Reset state
    #12;
    check("rst_glitch", glitch_out, 0);
    check("rst_busy", busy, 0);
    check("rst_fired", fired, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    tick();

    vecs[0] = mk_vec(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 0, 5, 3), 1, enc(8'hA0, 0), '0, '0, 1, 6, 3);
    vecs[1] = mk_vec(mk_cfg(8'hA0, 8'h5A, 8'hFF, 2, 0, 2, 2), 3, enc(8'hA0, 0), enc(8'h11, 0), enc(8'h5A, 0), 1, 3, 2);
    vecs[2] = mk_vec(mk_cfg(8'hA0, 8'h5A, 8'hFF, 2, 0, 2, 2), 3, enc(8'hA0, 0), enc(8'h11, 0), enc(8'h5B, 0), 0, 0, 0);
    vecs[3] = mk_vec(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 1, 1, 1), 1, enc(8'hA0, 1), '0, '0, 0, 0, 0);
    vecs[4] = mk_vec(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 0, 1, 1), 1, enc(8'hA0, 1), '0, '0, 1, 2, 1);
    vecs[5] = mk_vec(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 0, 0, 0), 1, enc(8'hA0, 0), '0, '0, 1, 1, 1);
    vecs[6] = mk_vec(mk_cfg(8'hA0, 8'h50, 8'hF0, 1, 0, 3, 4), 2, enc(8'hA0, 0), enc(8'h5F, 0), '0, 1, 4, 4);
    vecs[7] = mk_vec(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 0, 2, 2), 1, enc(8'hA2, 0), '0, '0, 0, 0, 0);
    vecs[8] = mk_vec(mk_cfg(8'hA0, 8'h33, 8'hFF, 1, 1, 0, 1), 2, enc(8'hA0, 0), enc(8'h33, 1), '0, 0, 0, 0);
    vecs[9] = mk_vec(mk_cfg(8'h3C, 8'hC3, 8'hFF, 1, 1, 0, 2), 2, enc(8'h3C, 0), enc(8'hC3, 0), '0, 1, 1, 2);

    for (int v = 0; v < NVEC; v++) begin
      do_abort();
      do_arm(vecs[v].cfg);
      do_sop();
      for (int i = 0; i < vecs[v].nb; i++) do_byte(vecs[v].b[i]);
      measure(20, rise, width);
      check($sformatf("vec%0d_rise", v), rise, vecs[v].exp_rise);
      check($sformatf("vec%0d_width", v), width, vecs[v].exp_width);
      check($sformatf("vec%0d_fired", v), fired, vecs[v].exp_fire);
      check($sformatf("vec%0d_state", v), state_dbg, vecs[v].exp_fire ? 6 : 1);
    end

    // Re-arm from DONE clears fired
    do_arm(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 0, 0, 0));
    check("rearm_fired", fired, 0);
    check("rearm_state", state_dbg, 1);
    check("rearm_busy", busy, 1);

    // Stop after first data byte: late data byte ignored, next transaction fires
    do_abort();
    do_arm(mk_cfg(8'hA0, 8'h5A, 8'hFF, 2, 0, 2, 2));
    do_sop(); do_byte(enc(8'hA0, 0)); do_byte(enc(8'h11, 0)); do_eot();
    check("eot_state", state_dbg, 1);
    do_byte(enc(8'h5A, 0));
    measure(8, rise, width);
    check("eot_no_pulse", width, 0);
    check("eot_still_armed", state_dbg, 1);
    do_sop(); do_byte(enc(8'hA0, 0)); do_byte(enc(8'h11, 0)); do_byte(enc(8'h5A, 0));
    measure(12, rise, width);
    check("eot_second_rise", rise, 3);
    check("eot_second_fired", fired, 1);

    // Repeated start mid-DATA restarts byte count
    do_abort();
    do_arm(mk_cfg(8'hA0, 8'h5A, 8'hFF, 2, 0, 2, 2));
    do_sop(); do_byte(enc(8'hA0, 0)); do_byte(enc(8'h11, 0)); do_sop();
    check("rs_state", state_dbg, 2);
    do_byte(enc(8'hA0, 0)); do_byte(enc(8'h11, 0)); do_byte(enc(8'h5A, 0));
    measure(12, rise, width);
    check("rs_rise", rise, 3);
    check("rs_width", width, 2);

    // arm during DELAY is ignored
    do_abort();
    do_arm(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 0, 4, 2));
    do_sop(); do_byte(enc(8'hA0, 0));
    tick();
    do_arm(mk_cfg(8'h55, 8'h00, 8'h00, 0, 0, 0, 1));
    check("armdly_state", state_dbg, 4);
    measure(12, rise, width);
    check("armdly_rise", rise + 2, 5);
    check("armdly_width", width, 2);

    // abort during PULSE
    do_abort();
    do_arm(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 0, 1, 10));
    do_sop(); do_byte(enc(8'hA0, 0));
    tick(); tick();
    check("abort_pre_glitch", glitch_out, 1);
    tick();
    do_abort();
    check("abort_glitch", glitch_out, 0);
    check("abort_state", state_dbg, 0);
    check("abort_fired", fired, 0);

    // Async reset during DELAY
    do_arm(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 0, 20, 2));
    do_sop(); do_byte(enc(8'hA0, 0)); tick(); tick();
    check("rstdly_busy_pre", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rstdly_busy", busy, 0);
    check("rstdly_state", state_dbg, 0);
    check("rstdly_glitch", glitch_out, 0);
    check("rstdly_fired", fired, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Async reset during PULSE
    do_arm(mk_cfg(8'hA0, 8'h00, 8'h00, 0, 0, 0, 10));
    do_sop(); do_byte(enc(8'hA0, 0)); tick();
    check("rstpls_pre", glitch_out, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rstpls_glitch", glitch_out, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized streams vs. transaction model
    for (int it = 0; it < 40; it++) begin
      c.addr = 8'($urandom); c.data = 8'($urandom); c.mask = 8'($urandom);
      c.idx = 4'($urandom_range(0, 3)); c.ack_req = 1'($urandom_range(0, 1));
      c.dly = 16'($urandom_range(0, 6)); c.pls = 8'($urandom_range(0, 4));
      for (int i = 0; i < NEV; i++) begin
        r = $urandom_range(0, 9);
        ev_kind[i] = (r < 2) ? EV_IDLE : (r < 4) ? EV_SOP : (r < 5) ? EV_EOT : EV_BYTE;
        case ($urandom_range(0, 2))
          0:       ev_byte[i] = {c.addr, 1'b0};
          1:       ev_byte[i] = {c.data ^ (8'($urandom) & ~c.mask), 1'b0};
          default: ev_byte[i] = {8'($urandom), 1'b0};
        endcase
        ev_byte[i][0] = ($urandom_range(0, 3) == 0);
      end
      fc = model_fire(c);
      d  = int'(c.dly);
      p  = (c.pls == 0) ? 1 : int'(c.pls);
      do_abort();
      check("rnd_idle", state_dbg, 0);
      do_arm(c);
      for (int s = 0; s < NEV + TAIL; s++) begin
        if (s < NEV) begin
          if (ev_kind[s] == EV_SOP) bus.sop = 1'b1;
          else if (ev_kind[s] == EV_EOT) bus.eot = 1'b1;
          else if (ev_kind[s] == EV_BYTE) begin
            bus.byte_in = ev_byte[s]; bus.byte_ready = 1'b1;
          end
        end
        tick();
        check($sformatf("rnd%0d_s%0d_glitch", it, s), glitch_out,
              (fc >= 0) && (s >= fc + d + 1) && (s <= fc + d + p));
        check($sformatf("rnd%0d_s%0d_fired", it, s), fired, (fc >= 0) && (s >= fc + d + p + 1));
        check($sformatf("rnd%0d_s%0d_busy", it, s), busy, !((fc >= 0) && (s >= fc + d + p + 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
